// File: rtl/fifo_thr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fifo_thr_pkg                                                |
// | Brief  : Shared types for the threshold FIFO (per-cycle op encoding) |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package fifo_thr_pkg;

  // Accepted operations in one cycle, encoded as {push_ok, pop_ok}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : fifo_thr_pkg
`default_nettype wire

// File: rtl/fifo_wrap_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fifo_wrap_ptr                                               |
// | Brief  : Pointer that wraps from DEPTH-1 back to 0 (any DEPTH >= 2)  |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module fifo_wrap_ptr #(
  parameter int DEPTH = 16,
  parameter int WIDTH = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  // Explicit compare so non-power-of-two depths wrap correctly
  localparam logic [WIDTH-1:0] c_last = WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0] r_ptr;

  // Pointer register: clear has priority over increment
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ptr <= '0;
    end else if (clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr_o = r_ptr;

endmodule : fifo_wrap_ptr
`default_nettype wire

// File: rtl/fifo_thr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fifo_thr                                                    |
// | Brief  : Single-clock FWFT FIFO, arbitrary depth, programmable       |
// |          almost-full/empty flags, sticky overflow/underflow flags    |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module fifo_thr
  import fifo_thr_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 16,
  parameter int PASS_FULL    = 1,
  parameter int PTR_WIDTH    = $clog2(BUFFER_DEPTH),
  parameter int CNT_WIDTH    = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  full_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  empty_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  input  logic [CNT_WIDTH-1:0]  afull_thr_i,
  input  logic [CNT_WIDTH-1:0]  aempty_thr_i,
  output logic                  afull_o,
  output logic                  aempty_o,
  input  logic                  clr_err_i,
  output logic                  ovf_o,
  output logic                  udf_o
);

  localparam logic [CNT_WIDTH-1:0] c_depth_cnt = CNT_WIDTH'(BUFFER_DEPTH);
  localparam logic                 c_pass_full = (PASS_FULL != 0);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [PTR_WIDTH-1:0]  w_wr_ptr;
  logic [PTR_WIDTH-1:0]  w_rd_ptr;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop_ok;
  logic                  w_push_ok;
  fifo_op_e              w_op;

  // Status derived from the registered count only, never from push/pop
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == c_depth_cnt);
  assign w_pop_ok  = pop_i & ~w_empty;
  assign w_push_ok = push_i & (~w_full | (c_pass_full & w_pop_ok));
  assign w_op      = fifo_op_e'({w_push_ok, w_pop_ok});

  fifo_wrap_ptr #(
    .DEPTH (BUFFER_DEPTH),
    .WIDTH (PTR_WIDTH)
  ) u_wr_ptr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .inc_i   (w_push_ok),
    .ptr_o   (w_wr_ptr)
  );

  fifo_wrap_ptr #(
    .DEPTH (BUFFER_DEPTH),
    .WIDTH (PTR_WIDTH)
  ) u_rd_ptr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .inc_i   (w_pop_ok),
    .ptr_o   (w_rd_ptr)
  );

  // Next occupancy: flush wins, simultaneous push+pop leaves count unchanged
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (flush_i) begin
      w_cnt_nxt = '0;
    end else begin
      case (w_op)
        OP_PUSH: w_cnt_nxt = r_cnt + 1'b1;
        OP_POP:  w_cnt_nxt = r_cnt - 1'b1;
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  // Count and watermark flags, flags computed from next count so they track cnt_o
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt    <= '0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_afull  <= (w_cnt_nxt >= afull_thr_i);
      r_aempty <= (w_cnt_nxt <= aempty_thr_i);
    end
  end

  // Storage: cleared on reset, written on accepted push unless flushing
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok && !flush_i) begin
      r_mem[w_wr_ptr] <= dat_i;
    end
  end

  // Sticky error flags: a new event in the same cycle beats the clear
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (push_i & ~w_push_ok & ~flush_i) | (r_ovf & ~clr_err_i);
      r_udf <= (pop_i & w_empty & ~flush_i) | (r_udf & ~clr_err_i);
    end
  end

  assign dat_o    = r_mem[w_rd_ptr];
  assign cnt_o    = r_cnt;
  assign empty_o  = w_empty;
  assign full_o   = w_full;
  assign afull_o  = r_afull;
  assign aempty_o = r_aempty;
  assign ovf_o    = r_ovf;
  assign udf_o    = r_udf;

endmodule : fifo_thr
`default_nettype wire

// File: tb/tb_fifo_thr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_fifo_thr                                                 |
// | Brief  : Self-checking bench, queue-based reference model            |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_fifo_thr;

  localparam int DW = 8;
  localparam int DEPTH = 5;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (PASS_FULL=1) stimulus and outputs
  logic          a_rst_n = 1'b0, a_flush = 1'b0, a_push = 1'b0, a_pop = 1'b0, a_clr = 1'b0;
  logic [DW-1:0] a_din = '0;
  logic [CW-1:0] a_athr = CW'(3), a_ethr = CW'(1);
  logic          a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
  logic [DW-1:0] a_dout;
  logic [CW-1:0] a_cnt;

  // DUT B (PASS_FULL=0) stimulus and outputs
  logic          b_rst_n = 1'b0, b_push = 1'b0, b_pop = 1'b0;
  logic [DW-1:0] b_din = '0;
  logic          b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
  logic [DW-1:0] b_dout;
  logic [CW-1:0] b_cnt;

  fifo_thr #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .PASS_FULL(1)) u_dut_a (
    .clk_i(clk), .rst_n_i(a_rst_n), .flush_i(a_flush), .push_i(a_push), .dat_i(a_din),
    .full_o(a_full), .pop_i(a_pop), .dat_o(a_dout), .empty_o(a_empty), .cnt_o(a_cnt),
    .afull_thr_i(a_athr), .aempty_thr_i(a_ethr), .afull_o(a_afull), .aempty_o(a_aempty),
    .clr_err_i(a_clr), .ovf_o(a_ovf), .udf_o(a_udf)
  );

  fifo_thr #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .PASS_FULL(0)) u_dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n), .flush_i(1'b0), .push_i(b_push), .dat_i(b_din),
    .full_o(b_full), .pop_i(b_pop), .dat_o(b_dout), .empty_o(b_empty), .cnt_o(b_cnt),
    .afull_thr_i(CW'(4)), .aempty_thr_i(CW'(0)), .afull_o(b_afull), .aempty_o(b_aempty),
    .clr_err_i(1'b0), .ovf_o(b_ovf), .udf_o(b_udf)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of DUT A: contents as a queue, flags as plain bits
  logic [DW-1:0] m_q[$];
  bit            m_ovf = 1'b0, m_udf = 1'b0, m_afull = 1'b0, m_aempty = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_a();
    int sz;
    sz = m_q.size();
    chk("a_cnt", 32'(a_cnt), 32'(sz));
    chk("a_empty", 32'(a_empty), 32'(sz == 0));
    chk("a_full", 32'(a_full), 32'(sz == DEPTH));
    chk("a_afull", 32'(a_afull), 32'(m_afull));
    chk("a_aempty", 32'(a_aempty), 32'(m_aempty));
    chk("a_ovf", 32'(a_ovf), 32'(m_ovf));
    chk("a_udf", 32'(a_udf), 32'(m_udf));
    if (sz > 0) chk("a_dat", 32'(a_dout), 32'(m_q[0]));
  endtask

  // Apply one cycle of stimulus to DUT A (called at a negedge), advance the
  // model by the same rules, then check at the following negedge
  task automatic drive(input bit rst_n, input bit fl, input bit pu, input bit po,
                       input logic [DW-1:0] d, input bit clr);
    bit emp, ful, pop_ok, push_ok;
    a_rst_n = rst_n; a_flush = fl; a_push = pu; a_pop = po; a_din = d; a_clr = clr;
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 0; m_udf = 0; m_afull = 0; m_aempty = 1;
    end else begin
      emp     = (m_q.size() == 0);
      ful     = (m_q.size() == DEPTH);
      pop_ok  = po && !emp;
      push_ok = pu && (!ful || pop_ok);
      m_ovf   = (pu && !push_ok && !fl) || (m_ovf && !clr);
      m_udf   = (po && emp && !fl) || (m_udf && !clr);
      if (fl) m_q.delete();
      else begin
        if (pop_ok) void'(m_q.pop_front());
        if (push_ok) m_q.push_back(d);
      end
      m_afull  = (m_q.size() >= int'(a_athr));
      m_aempty = (m_q.size() <= int'(a_ethr));
    end
    @(negedge clk);
    check_a();
  endtask

  // Drive DUT B for one cycle; checks are done by the caller
  task automatic b_step(input bit rst_n, input bit pu, input bit po, input logic [DW-1:0] d);
    b_rst_n = rst_n; b_push = pu; b_pop = po; b_din = d;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] v;
    @(negedge clk);
    check_a();
    chk("a_rst_dat", 32'(a_dout), 32'h0);

    // ---------------- DUT B: PASS_FULL=0 refuses push while full ----------
    b_step(1'b0, 0, 0, 8'h00);
    chk("b_rst_cnt", 32'(b_cnt), 0);
    for (int i = 1; i <= DEPTH; i++) b_step(1'b1, 1, 0, 8'(8'h11 * i));
    chk("b_full", 32'(b_full), 1);
    b_step(1'b1, 1, 1, 8'hAA);
    chk("b_pf0_cnt", 32'(b_cnt), 4);
    chk("b_pf0_ovf", 32'(b_ovf), 1);
    chk("b_pf0_full", 32'(b_full), 0);
    for (int i = 2; i <= DEPTH; i++) begin
      chk("b_pf0_dat", 32'(b_dout), 32'(8'h11 * i));
      b_step(1'b1, 0, 1, 8'h00);
    end
    chk("b_empty", 32'(b_empty), 1);

    // ---------------- DUT A directed scenarios -----------------------------
    a_athr = CW'(3); a_ethr = CW'(1);
    drive(1, 0, 0, 0, 8'h00, 0);                 // release reset
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 0, 1, 0, 8'(8'h11 * i), 0);
      if (i == 3) chk("afull_at3", 32'(a_afull), 1);
    end
    chk("full_after5", 32'(a_full), 1);
    drive(1, 0, 1, 0, 8'h66, 0);                 // refused
    chk("ovf_6th", 32'(a_ovf), 1);
    chk("cnt_6th", 32'(a_cnt), 5);
    drive(1, 0, 1, 1, 8'hAA, 1);                 // pass-through while full
    chk("pass_cnt", 32'(a_cnt), 5);
    for (int i = 0; i < DEPTH; i++) begin
      v = a_dout;
      drive(1, 0, 0, 1, 8'h00, 0);
      if (i == DEPTH - 1) chk("pass_last", 32'(v), 32'hAA);
      if (i == 3) chk("aempty_at1", 32'(a_aempty), 1);
    end
    drive(1, 0, 0, 1, 8'h00, 0);                 // underflow
    chk("udf_set", 32'(a_udf), 1);
    drive(1, 0, 0, 1, 8'h00, 1);                 // clear + new underflow
    chk("udf_set_wins", 32'(a_udf), 1);
    drive(1, 0, 0, 0, 8'h00, 1);
    chk("udf_cleared", 32'(a_udf), 0);
    drive(1, 0, 1, 1, 8'h5A, 0);                 // empty push+pop
    chk("empty_pp_cnt", 32'(a_cnt), 1);
    for (int i = 0; i < 12; i++) drive(1, 0, 1, (i % 2) == 1, 8'(8'h30 + i), 0);
    drive(1, 1, 1, 0, 8'hEE, 0);                 // flush beats push
    chk("flush_cnt", 32'(a_cnt), 0);
    chk("flush_udf_kept", 32'(a_udf), 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 8'(8'hC0 + i), 0);
    drive(0, 0, 1, 1, 8'hFF, 0);                 // reset mid-stream
    chk("rst_dat", 32'(a_dout), 0);
    a_athr = CW'(0); a_ethr = CW'(0);
    drive(1, 0, 0, 0, 8'h00, 0);

    // ---------------- DUT A randomized phase -------------------------------
    for (int i = 0; i < 3000; i++) begin
      int pp, pq;
      pp = ((i / 200) % 3 == 0) ? 80 : ((i / 200) % 3 == 1) ? 30 : 55;
      pq = 100 - pp;
      if ($urandom_range(0, 19) == 0) begin
        a_athr = CW'($urandom_range(0, DEPTH));
        a_ethr = CW'($urandom_range(0, DEPTH));
      end
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < pp),
            ($urandom_range(0, 99) < pq),
            DW'($urandom),
            ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo_thr
`default_nettype wire
